// File: rtl/jt12_sh_acc.sv
// Time-multiplexed per-lane accumulator over a recirculating loop of `lanes` stages.
// Define JT12_SHACC_SAT_EN to clamp out-of-range sums and pulse ovf; default build wraps.
`timescale 1ns/1ps
module jt12_sh_acc #(
  parameter int unsigned win   = 14,
  parameter int unsigned wout  = 15,
  parameter int unsigned lanes = 6,
  parameter int unsigned ops   = 4
) (
  input  logic                                         rst,
  input  logic                                         clk,
  input  logic                                         clk_en,
  input  logic                                         zero,
  input  logic signed [win-1:0]                        din,
  input  logic                                         en,
  output logic signed [wout-1:0]                       dout,
  output logic [((lanes > 1) ? $clog2(lanes) : 1)-1:0] dout_lane,
  output logic                                         dout_valid,
  output logic                                         locked,
  output logic                                         sync_err,
  output logic                                         ovf
);

  localparam int unsigned LW = (lanes > 1) ? $clog2(lanes) : 1;
  localparam int unsigned OW = (ops > 1) ? $clog2(ops) : 1;

  logic [LW-1:0]   r_lane;
  logic [OW-1:0]   r_op;
  logic            r_locked;
  logic [wout-1:0] r_loop [lanes];
  logic [wout-1:0] r_dout;
  logic [LW-1:0]   r_dout_lane;
  logic            r_valid;
  logic            r_sync_err;

  logic [LW-1:0]   w_lane;
  logic [OW-1:0]   w_op;
  logic [LW-1:0]   w_lane_nx;
  logic [OW-1:0]   w_op_nx;
  logic            w_last_lane;
  logic            w_last_op;
  logic [wout-1:0] w_head;
  logic [wout-1:0] w_base;
  logic signed [wout-1:0] w_add;
  logic [wout-1:0] w_sum;
  logic            w_lock;
  logic            w_emit;
  logic            w_sync_err;
`ifdef JT12_SHACC_SAT_EN
  logic [wout:0]   w_sum_x;
  logic            w_clip;
  logic            r_ovf;
`endif

  // Slot decode, next slot, and the per-tick add into the loop head.
  always_comb begin
    w_lane      = zero ? '0 : r_lane;
    w_op        = zero ? '0 : r_op;
    w_last_lane = (w_lane == LW'(lanes - 1));
    w_last_op   = (w_op == OW'(ops - 1));
    w_lane_nx   = w_last_lane ? '0 : w_lane + LW'(1);
    w_op_nx     = w_op;
    if (w_last_lane) begin
      w_op_nx = w_last_op ? '0 : w_op + OW'(1);
    end
    w_head      = r_loop[lanes-1];
    // op 0 starts a fresh lane sum so stale or partial contents never carry over
    w_base      = (w_op == '0) ? '0 : w_head;
    w_add       = en ? wout'(din) : '0;
`ifdef JT12_SHACC_SAT_EN
    w_sum_x     = {w_base[wout-1], w_base} + {w_add[wout-1], w_add};
    w_clip      = w_sum_x[wout] ^ w_sum_x[wout-1];
    w_sum       = w_sum_x[wout-1:0];
    if (w_clip) begin
      w_sum = w_sum_x[wout] ? {1'b1, {(wout-1){1'b0}}} : {1'b0, {(wout-1){1'b1}}};
    end
`else
    w_sum       = w_base + w_add;
`endif
    w_lock      = r_locked | zero;
    w_emit      = w_last_op & w_lock;
    w_sync_err  = zero & r_locked & ((r_lane != '0) | (r_op != '0));
  end

  // State advances only on clk_en; the pulse outputs self-clear on every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane      <= '0;
      r_op        <= '0;
      r_locked    <= 1'b0;
      for (int i = 0; i < int'(lanes); i++) r_loop[i] <= '0;
      r_dout      <= '0;
      r_dout_lane <= '0;
      r_valid     <= 1'b0;
      r_sync_err  <= 1'b0;
`ifdef JT12_SHACC_SAT_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      r_valid    <= 1'b0;
      r_sync_err <= 1'b0;
`ifdef JT12_SHACC_SAT_EN
      r_ovf      <= 1'b0;
`endif
      if (clk_en) begin
        r_lane     <= w_lane_nx;
        r_op       <= w_op_nx;
        r_locked   <= w_lock;
        r_loop[0]  <= w_sum;
        for (int i = 1; i < int'(lanes); i++) r_loop[i] <= r_loop[i-1];
        r_sync_err <= w_sync_err;
`ifdef JT12_SHACC_SAT_EN
        r_ovf      <= w_clip;
`endif
        if (w_emit) begin
          r_dout      <= w_sum;
          r_dout_lane <= w_lane;
          r_valid     <= 1'b1;
        end
      end
    end
  end

  assign dout       = r_dout;
  assign dout_lane  = r_dout_lane;
  assign dout_valid = r_valid;
  assign locked     = r_locked;
  assign sync_err   = r_sync_err;
`ifdef JT12_SHACC_SAT_EN
  assign ovf        = r_ovf;
`else
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_jt12_sh_acc.sv
// Directed bench for jt12_sh_acc: round timing, lane sums, overflow, freeze, resync, async reset.
`timescale 1ns/1ps
module tb_jt12_sh_acc;

  logic               rst;
  logic               clk;
  logic               clk_en;
  logic               zero;
  logic signed [13:0] din;
  logic               en;
  logic signed [14:0] dout;
  logic [2:0]         dout_lane;
  logic               dout_valid;
  logic               locked;
  logic               sync_err;
  logic               ovf;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic z;
    logic e;
    int   d;
    logic v;
    int   lane;
    int   dout;
  } vec_t;

  vec_t tbl [24];

  jt12_sh_acc dut (
    .rst(rst), .clk(clk), .clk_en(clk_en), .zero(zero), .din(din), .en(en),
    .dout(dout), .dout_lane(dout_lane), .dout_valid(dout_valid),
    .locked(locked), .sync_err(sync_err), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Drive one clk cycle's inputs away from the edge, then sample just after it.
  task automatic tick(input logic ce, input logic z, input logic e, input int d);
    @(negedge clk);
    clk_en = ce;
    zero   = z;
    en     = e;
    din    = 14'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input int lane,
                            input int d, input logic se);
    chk({tag, ".valid"}, int'(dout_valid), int'(v));
    if (v) chk({tag, ".lane"}, int'(dout_lane), lane);
    chk({tag, ".dout"}, int'(dout), d);
    chk({tag, ".sync_err"}, int'(sync_err), int'(se));
  endtask

  // One aligned round with din=1 on every slot; prev is dout held before the first emission.
  task automatic unit_round(input string tag, input int prev, input int nticks);
    for (int k = 0; k < nticks; k++) begin
      tick(1'b1, k == 0, 1'b1, 1);
      expect_out($sformatf("%s[%0d]", tag, k), k >= 18, k - 18, (k >= 18) ? 4 : prev, 1'b0);
    end
  endtask

  // Lane 0 gets d on all four ops, other lanes are disabled with garbage on din.
  task automatic lane0_round(input string tag, input int d, input int exp_d, input logic exp_ovf);
    for (int k = 0; k < 24; k++) begin
      tick(1'b1, k == 0, (k % 6) == 0, ((k % 6) == 0) ? d : 1234);
      expect_out($sformatf("%s[%0d]", tag, k), k >= 18, k - 18,
                 (k == 18) ? exp_d : 0, 1'b0);
      if (k == 18) chk({tag, ".ovf"}, int'(ovf), int'(exp_ovf));
      if (k == 19) chk({tag, ".ovf_clear"}, int'(ovf), 0);
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; zero = 1'b0; en = 1'b0; din = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.dout", int'(dout), 0);
    chk("rst.lane", int'(dout_lane), 0);
    chk("rst.valid", int'(dout_valid), 0);
    chk("rst.locked", int'(locked), 0);
    chk("rst.sync_err", int'(sync_err), 0);
    chk("rst.ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;

    // Constant din=1: two rounds, lock on the first zero tick
    for (int k = 0; k < 48; k++) begin
      tick(1'b1, k == 0, 1'b1, 1);
      expect_out($sformatf("s1[%0d]", k), (k % 24) >= 18, (k % 24) - 18,
                 (k >= 18) ? 4 : 0, 1'b0);
      if (k == 0) chk("s1.locked", int'(locked), 1);
    end

    // clk_en freeze right after a valid pulse, with zero/en/din toggling
    for (int k = 0; k < 19; k++) begin
      tick(1'b1, 1'b0, 1'b1, 1);
      expect_out($sformatf("s4a[%0d]", k), k >= 18, k - 18, 4, 1'b0);
    end
    for (int f = 0; f < 5; f++) begin
      tick(1'b0, f[0], ~f[0], (f * 3001) - 7000);
      expect_out($sformatf("s4f[%0d]", f), 1'b0, 0, 4, 1'b0);
      chk($sformatf("s4f[%0d].locked", f), int'(locked), 1);
    end
    for (int k = 19; k < 24; k++) begin
      tick(1'b1, 1'b0, 1'b1, 1);
      expect_out($sformatf("s4b[%0d]", k), 1'b1, k - 18, 4, 1'b0);
    end

    // Misaligned zero at cnt=9, then a clean round with no partial-sum leak
    for (int k = 0; k < 9; k++) begin
      tick(1'b1, 1'b0, 1'b1, 1);
      expect_out($sformatf("s5a[%0d]", k), 1'b0, 0, 4, 1'b0);
    end
    tick(1'b1, 1'b1, 1'b1, 1);
    expect_out("s5.resync", 1'b0, 0, 4, 1'b1);
    for (int k = 1; k < 24; k++) begin
      tick(1'b1, 1'b0, 1'b1, 1);
      expect_out($sformatf("s5b[%0d]", k), k >= 18, k - 18, 4, 1'b0);
    end

    // Table: lane 2 sums 1000+2000-500+3, other lanes disabled
    for (int i = 0; i < 24; i++) begin
      tbl[i].z    = (i == 0);
      tbl[i].e    = ((i % 6) == 2);
      tbl[i].d    = 777;
      tbl[i].v    = (i >= 18);
      tbl[i].lane = i - 18;
      tbl[i].dout = (i < 18) ? 4 : 0;
    end
    tbl[2].d  = 1000;
    tbl[8].d  = 2000;
    tbl[14].d = -500;
    tbl[20].d = 3;
    tbl[20].dout = 2503;
    for (int i = 0; i < 24; i++) begin
      tick(1'b1, tbl[i].z, tbl[i].e, tbl[i].d);
      expect_out($sformatf("s2[%0d]", i), tbl[i].v, tbl[i].lane, tbl[i].dout, 1'b0);
    end

    // Full-scale sums on lane 0
`ifdef JT12_SHACC_SAT_EN
    lane0_round("s3p", 8191, 16383, 1'b1);
    lane0_round("s3n", -8192, -16384, 1'b1);
`else
    lane0_round("s3p", 8191, -4, 1'b0);
    lane0_round("s3n", -8192, 0, 1'b0);
`endif

    // Async reset between edges while dout=4 and dout_valid is high
    unit_round("s6a", 0, 21);
    #2;
    rst = 1'b1;
    #1;
    chk("s6.dout", int'(dout), 0);
    chk("s6.lane", int'(dout_lane), 0);
    chk("s6.valid", int'(dout_valid), 0);
    chk("s6.locked", int'(locked), 0);
    chk("s6.sync_err", int'(sync_err), 0);
    chk("s6.ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick(1'b1, 1'b0, 1'b1, 1);
      expect_out($sformatf("s6u[%0d]", k), 1'b0, 0, 0, 1'b0);
      chk($sformatf("s6u[%0d].locked", k), int'(locked), 0);
    end
    unit_round("s6r", 0, 24);
    chk("s6r.locked", int'(locked), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jt12_sh_acc.md
Name: jt12_sh_acc

Overview:
- Time-multiplexed per-lane accumulator. It sits directly downstream of the slot delay lines (the clk_en-gated shift registers) and consumes their per-slot operator samples.
- Each operator slot of a round adds into a per-lane running sum. The sum is held in an internal recirculating loop of `lanes` stages. A completed lane sum is emitted once per round on that lane's last operator slot.
- Output feeds the mixer/DAC path.

Parameters:
- `win`, 14, input sample width (signed two's complement).
- `wout`, 15, accumulator and output width (signed); must be ≥ `win`.
- `lanes`, 6, number of lanes (channels); equals the internal loop depth.
- `ops`, 4, operator passes per lane per round; round length = `ops` × `lanes` ticks.

Ports:
- `rst`: input, 1. Asynchronous active-high reset.
- `clk`: input, 1. Single clock.
- `clk_en`: input, 1. Tick enable; all state advances only on a `clk` edge with `clk_en`=1.
- `zero`: input, 1. Marks the tick that is slot 0 of a round; sampled only when `clk_en`=1.
- `din`: input, `win`. Signed sample for the current slot.
- `en`: input, 1. 1 = add `din` this slot; 0 = add zero.
- `dout`: output, `wout`. Signed completed lane sum.
- `dout_lane`: output, ceil(log2(`lanes`)). Lane index of `dout`.
- `dout_valid`: output, 1. One-`clk` pulse when `dout` updates.
- `locked`: output, 1. High once a `zero` has been seen since reset.
- `sync_err`: output, 1. One-`clk` pulse on a misaligned `zero`.
- `ovf`: output, 1. One-`clk` pulse when a sum clipped (feature-dependent).

Behaviour:
- Reset is asynchronous and active-high. All loop stages, the slot counter, `dout`, `dout_lane`, `dout_valid`, `locked`, `sync_err` and `ovf` clear to 0.
- Slot counter `cnt` runs 0 .. `ops`·`lanes`−1. Decode: `lane` = `cnt` mod `lanes`, `op` = `cnt` / `lanes`.
- On a tick with `zero`=1, the slot is taken as `cnt`=0 and the counter holds 1 afterwards. Otherwise `cnt` increments, wrapping at the round end.
- `zero` with `clk_en`=0 is ignored. `clk_en`=0 freezes all state.
- `sync_err` pulses if `zero`=1 on a tick while `locked`=1 and the expected `cnt` ≠ 0. The counter still resyncs to 0.
- `locked` sets on the first `zero` tick and stays high until reset.
- Per tick datapath:
  - `head` = last loop stage.
  - base = 0 if `op`=0, else `head`.
  - sum = base + (`en` ? sign-extended `din` : 0), computed at `wout`+1 bits, then reduced to `wout` (see Optional Feature).
  - sum is shifted into loop stage 0; all stages advance by one.
- A lane's value re-enters `head` exactly `lanes` ticks later, i.e. on that lane's next op.
- Emission: on a tick with `op`=`ops`−1 and `locked`=1 (including the lock tick itself):
  - `dout` ← sum, `dout_lane` ← `lane`, `dout_valid`=1 for that `clk` only.
  - Latency: the same edge as the final slot's `din`.
- With `locked`=0, the loop still runs but `dout_valid` stays 0 and `dout` holds.
- `op`=0 discards the old loop contents. A resync or reset mid-round therefore never leaks partial sums into the next round.
- `dout` holds between pulses.
- `dout_valid`, `sync_err` and `ovf` deassert on the next `clk` edge regardless of `clk_en`.

Optional Feature:
- Macro `JT12_SHACC_SAT_EN`.
- Defined:
  - A sum outside [−2^(`wout`−1), 2^(`wout`−1)−1] clamps to the nearest limit.
  - `ovf` pulses on that tick (one `clk`, same timing as `dout_valid`).
- Undefined:
  - The sum wraps (two's-complement truncation to `wout` bits).
  - `ovf` is tied to 0; no clamp logic is built.

Test Plan:
1. Reset, one `zero` tick, then constant `din`=1, `en`=1, `clk_en`=1 each `clk` → `dout_valid` on ticks 18..23 after `zero`, `dout_lane` 0..5, `dout`=4 each. The pattern repeats every 24 ticks and `sync_err` never pulses.
2. Lane 2 gets `din` = 1000, 2000, −500, 3 on ops 0..3; other lanes get `en`=0 → on tick 20, `dout_lane`=2 with `dout`=2503. Other lanes output 0.
3. Lane 0 `din`=8191 on all four ops:
   - Macro defined: `dout`=16383 with an `ovf` pulse.
   - Macro undefined: `dout`=−4 (32764 mod 2^15), `ovf`=0.
   - Repeat with −8192 ×4, macro defined → `dout`=−16384 with an `ovf` pulse.
4. Hold `clk_en`=0 for 5 `clk` mid-round with `din` toggling → no counter, loop or output change. Resuming `clk_en` continues the exact tick sequence, and sums match scenario 1.
5. Locked and running; assert `zero` at `cnt`=9 → `sync_err` pulses once. The next `dout_valid` is lane 0 at 18 ticks after the new `zero`, with `dout`=4 (no partial sum from the broken round).
6. Assert `rst` asynchronously mid-round, between `clk` edges, with `dout`=4 → all outputs read 0 before the next edge. `locked`=0 and no `dout_valid` occurs until a new `zero`.
